// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-port controller routing loads/stores to backing memory or an MMIO counter/LED bank
module data_mem_ctrl #(
   parameter int WORD_SIZE = 16,
   parameter int MEM_WORDS = 256,
   parameter int TIMEOUT   = 15
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic [WORD_SIZE-1:0] DataAddr,
   input  logic [WORD_SIZE-1:0] DataOut,
   input  logic                 ReadData,
   input  logic                 WriteData,
   output logic [WORD_SIZE-1:0] DataIn,
   output logic                 DataDone,
   output logic [WORD_SIZE-1:0] MemAddr,
   output logic [WORD_SIZE-1:0] MemWData,
   output logic                 MemRead,
   output logic                 MemWrite,
   input  logic [WORD_SIZE-1:0] MemRData,
   input  logic                 MemReady,
   output logic [WORD_SIZE-1:0] Leds,
   output logic                 BusError
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [WORD_SIZE-1:0] MEM_LIM  = WORD_SIZE'(MEM_WORDS);
   localparam logic [WORD_SIZE-1:0] CNT_ADDR = WORD_SIZE'('hFFF0);
   localparam logic [WORD_SIZE-1:0] LED_ADDR = WORD_SIZE'('hFFF1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

   state_t state, state_next;
   logic [WORD_SIZE-1:0] cycle_cnt;
   logic [CW-1:0] wait_cnt;
   logic req, is_mem, abort;

   always_comb begin
      req = ReadData | WriteData;
      is_mem = DataAddr < MEM_LIM;
      abort = !MemReady && wait_cnt == WAIT_MAX;
      state_next = state == IDLE ? (req ? (is_mem ? MEM : DONE) : IDLE) :
                   state == MEM  ? (MemReady || abort ? DONE : MEM) : IDLE;
   end

   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) state <= IDLE;
      else state <= state_next;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         DataIn    <= '0;
         DataDone  <= 1'b0;
         MemAddr   <= '0;
         MemWData  <= '0;
         MemRead   <= 1'b0;
         MemWrite  <= 1'b0;
         Leds      <= '0;
         BusError  <= 1'b0;
         cycle_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + WORD_SIZE'(1);
         DataDone  <= state_next == DONE;
         unique case (state)
            IDLE: if (req) begin
               wait_cnt <= '0;
               if (ReadData && WriteData) BusError <= 1'b1;
               if (is_mem) begin
                  MemAddr  <= DataAddr;
                  MemWData <= DataOut;
                  MemWrite <= WriteData;
                  MemRead  <= !WriteData;
               end else if (DataAddr == CNT_ADDR) begin
                  if (WriteData) BusError <= 1'b1;
                  else DataIn <= cycle_cnt;
               end else if (DataAddr == LED_ADDR) begin
                  if (WriteData) Leds <= DataOut;
                  else DataIn <= Leds;
               end else begin
                  BusError <= 1'b1;
                  if (!WriteData) DataIn <= '0;
               end
            end
            MEM: begin
               if (!MemReady) wait_cnt <= wait_cnt + CW'(1);
               // an aborted read completes with zero data and flags the error
               if (MemReady || abort) begin
                  MemRead  <= 1'b0;
                  MemWrite <= 1'b0;
                  if (MemRead) DataIn <= MemReady ? MemRData : '0;
                  if (!MemReady) BusError <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: table-driven and directed checks of data_mem_ctrl against a delayed-ready memory model
module tb_data_mem_ctrl;
   logic        Clock = 1'b0;
   logic        Resetn = 1'b1;
   logic [15:0] DataAddr = '0, DataOut = '0, MemRData = '0;
   logic        ReadData = 1'b0, WriteData = 1'b0, MemReady = 1'b0;
   logic [15:0] DataIn, MemAddr, MemWData, Leds;
   logic        DataDone, MemRead, MemWrite, BusError;

   data_mem_ctrl dut (
      .Clock(Clock), .Resetn(Resetn), .DataAddr(DataAddr), .DataOut(DataOut),
      .ReadData(ReadData), .WriteData(WriteData), .DataIn(DataIn), .DataDone(DataDone),
      .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemRData(MemRData), .MemReady(MemReady), .Leds(Leds), .BusError(BusError)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0, n_fail = 0;
   int mem_delay = 0, strobe_n = 0;
   logic hang = 1'b0;
   logic [15:0] mem [256];
   logic [15:0] snap_addr, snap_wdata;
   logic snap_wr;

   // memory model: MemReady rises after mem_delay low strobe cycles, never while hang
   always @(negedge Clock) begin
      if (MemRead || MemWrite) begin
         strobe_n++;
         MemReady = !hang && strobe_n > mem_delay;
         MemRData = mem[MemAddr[7:0]];
         if (MemReady && MemWrite) mem[MemAddr[7:0]] = MemWData;
      end else begin
         strobe_n = 0;
         MemReady = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic access(input logic [15:0] addr, input logic [15:0] wdata, input logic rd,
                         input logic wr, input int dly, output int lat, output int strobes);
      mem_delay = dly;
      DataAddr = addr;
      DataOut = wdata;
      ReadData = rd;
      WriteData = wr;
      lat = -1;
      strobes = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clock);
         if (MemRead || MemWrite) strobes++;
         if (c == 1) begin
            snap_addr = MemAddr;
            snap_wdata = MemWData;
            snap_wr = MemWrite;
         end
         if (DataDone) begin
            lat = c;
            break;
         end
         @(posedge Clock);
         #1;
      end
      ReadData = 1'b0;
      WriteData = 1'b0;
      if (lat < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL access_%h: no DataDone within 40 cycles", addr);
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clock);
         #1;
      end
   endtask

   typedef struct {
      logic [15:0] addr, wdata;
      logic rd, wr, is_mem;
      int dly;
      logic [15:0] exp_data;
      int exp_lat;
      logic exp_err;
      logic [15:0] exp_leds;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, sc, d;
      logic [15:0] a, b;
      vecs[0] = '{16'h0005, 16'h1234, 0, 1, 1, 0, 16'h0000, 2, 0, 16'h0000};
      vecs[1] = '{16'h0005, 16'h0000, 1, 0, 1, 3, 16'h1234, 5, 0, 16'h0000};
      vecs[2] = '{16'hFFF1, 16'hA5A5, 0, 1, 0, 0, 16'h1234, 1, 0, 16'hA5A5};
      vecs[3] = '{16'hFFF1, 16'h0000, 1, 0, 0, 0, 16'hA5A5, 1, 0, 16'hA5A5};
      vecs[4] = '{16'h00FF, 16'hBEEF, 0, 1, 1, 1, 16'hA5A5, 3, 0, 16'hA5A5};
      vecs[5] = '{16'h00FF, 16'h0000, 1, 0, 1, 2, 16'hBEEF, 4, 0, 16'hA5A5};
      vecs[6] = '{16'h0100, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 1, 16'hA5A5};
      vecs[7] = '{16'hFFF0, 16'h1111, 0, 1, 0, 0, 16'h0000, 1, 1, 16'hA5A5};
      vecs[8] = '{16'hFFF1, 16'h5A5A, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h5A5A};
      vecs[9] = '{16'h0005, 16'h0000, 1, 0, 1, 0, 16'h1234, 2, 1, 16'h5A5A};
      for (int i = 0; i < 256; i++) mem[i] = '0;

      #1 Resetn = 1'b0;
      @(negedge Clock);
      check("reset_outputs", {DataIn, DataDone, MemRead, MemWrite, BusError}, '0);
      check("reset_mem_bus", {MemAddr, MemWData}, '0);
      check("reset_leds", Leds, '0);
      @(posedge Clock);
      #1 Resetn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         access(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, vecs[i].dly, lat, sc);
         check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_datain", i), DataIn, vecs[i].exp_data);
         check($sformatf("v%0d_buserror", i), BusError, vecs[i].exp_err);
         check($sformatf("v%0d_leds", i), Leds, vecs[i].exp_leds);
         check($sformatf("v%0d_strobes", i), sc, vecs[i].is_mem ? vecs[i].dly + 1 : 0);
         if (vecs[i].is_mem) begin
            check($sformatf("v%0d_memaddr", i), snap_addr, vecs[i].addr);
            check($sformatf("v%0d_memwrite", i), snap_wr, vecs[i].wr);
            if (vecs[i].wr) check($sformatf("v%0d_memwdata", i), snap_wdata, vecs[i].wdata);
         end
      end

      // reset while a read is stalled in MEM
      hang = 1'b1;
      DataAddr = 16'h0009;
      ReadData = 1'b1;
      tick(1);
      check("mid_memread_before_reset", MemRead, 1'b1);
      #1 Resetn = 1'b0;
      #1;
      check("async_memread_drop", MemRead, 1'b0);
      check("async_reset_outputs", {DataIn, DataDone, MemWrite, BusError, Leds}, '0);
      check("async_reset_mem_bus", {MemAddr, MemWData}, '0);
      ReadData = 1'b0;
      hang = 1'b0;
      tick(1);
      Resetn = 1'b1;
      tick(1);
      access(16'hFFF1, 16'h0000, 1, 0, 0, lat, sc);
      check("post_reset_idle_latency", lat, 1);
      check("post_reset_leds_read", DataIn, 16'h0000);

      // timeout abort
      access(16'h0005, 16'h0000, 1, 0, 0, lat, sc);
      check("pre_timeout_datain", DataIn, 16'h1234);
      check("pre_timeout_buserror", BusError, 1'b0);
      hang = 1'b1;
      access(16'h0007, 16'h0000, 1, 0, 0, lat, sc);
      hang = 1'b0;
      check("timeout_latency", lat, 16);
      check("timeout_strobes", sc, 15);
      check("timeout_datain", DataIn, 16'h0000);
      check("timeout_buserror", BusError, 1'b1);
      access(16'hFFF1, 16'h0F0F, 0, 1, 0, lat, sc);
      check("sticky_leds", Leds, 16'h0F0F);
      check("sticky_err_mmio", BusError, 1'b1);
      access(16'h0005, 16'h0000, 1, 0, 1, lat, sc);
      check("sticky_mem_data", DataIn, 16'h1234);
      check("sticky_err_mem", BusError, 1'b1);

      // cycle counter spacing and wrap
      access(16'hFFF0, 16'h0000, 1, 0, 0, lat, sc);
      a = DataIn;
      tick(8);
      access(16'hFFF0, 16'h0000, 1, 0, 0, lat, sc);
      b = DataIn;
      check("counter_delta_10", 16'(b - a), 16'd10);
      d = 65536 - int'(b);
      tick(d - 4);
      access(16'hFFF0, 16'h0000, 1, 0, 0, lat, sc);
      check("counter_fffe", DataIn, 16'hFFFE);
      access(16'hFFF0, 16'h0000, 1, 0, 0, lat, sc);
      check("counter_wrap_0", DataIn, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
